shift_seq_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/shift_seq_ctrl.sv | 112 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   - state_t : shift sequencer FSM encoding (IDLE/ISSUE/CAPTURE/DONE)
//   - SH_*    : SHIFT_UNIT ALU_FUN codes
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [1:0] SH_A_RIGHT = 2'b00;
    localparam logic [1:0] SH_A_LEFT  = 2'b01;
    localparam logic [1:0] SH_B_RIGHT = 2'b10;
    localparam logic [1:0] SH_B_LEFT  = 2'b11;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Multi-bit shift sequencer driving the 1-bit SHIFT_UNIT.
// An N-bit shift is run as N ISSUE/CAPTURE iterations; each registered
// SHIFT_UNIT result is fed back as the next operand.
// Ports:
//   CLK, RST             clock, async active-high reset
//   start/dir/operand/amount  request (sampled only in IDLE)
//   busy                 state != IDLE
//   done/err/result      one-cycle completion pulse, error flag valid with done,
//                        result held until the next completion
//   su_enable/su_alu_fun/su_a/su_b   to SHIFT_UNIT
//   su_out/su_flag                   from SHIFT_UNIT
module shift_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             su_enable,
    output logic [1:0]       su_alu_fun,
    output logic [WIDTH-1:0] su_a,
    output logic [WIDTH-1:0] su_b,
    input  logic [WIDTH-1:0] su_out,
    input  logic             su_flag
);

    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

    state_t           state, nxt;
    logic [WIDTH-1:0] acc;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] amt_sat;
    logic             dir_q;
    logic             err_q;

    // Shifting by WIDTH or more always yields zero, so cap the iteration
    // count there to bound latency.
    assign amt_sat = (amount >= WIDTH_AMT) ? WIDTH_AMT : amount;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
            result <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= operand;
                        dir_q <= dir;
                        err_q <= 1'b0;
                        cnt   <= amt_sat;
                    end
                end
                CAPTURE: begin
                    acc <= su_out;
                    cnt <= cnt - 1'b1;
                    if (!su_flag) err_q <= 1'b1;
                end
                DONE: result <= acc;
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt        = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        err        = 1'b0;
        su_enable  = 1'b0;
        su_alu_fun = SH_A_RIGHT;
        case (state)
            IDLE: begin
                if (start) nxt = (amt_sat != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                su_enable  = 1'b1;
                su_alu_fun = {1'b0, dir_q};
                nxt        = CAPTURE;
            end
            CAPTURE: begin
                // A missing flag means the unit did not shift; stop early.
                if (!su_flag || cnt == AMT_W'(1)) nxt = DONE;
                else                             nxt = ISSUE;
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign su_a = acc;
    assign su_b = '0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural SHIFT_UNIT beside it.
module tb_shift_seq_ctrl;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start, dir;
    logic [W-1:0]  operand;
    logic [AW-1:0] amount;
    logic          busy, done, err;
    logic [W-1:0]  result;
    logic          su_enable;
    logic [1:0]    su_alu_fun;
    logic [W-1:0]  su_a, su_b, su_out;
    logic          su_flag;

    logic          su_rst_n;
    logic [W-1:0]  m_out;
    logic          m_flag;
    logic          kill;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    shift_seq_ctrl #(.WIDTH(W), .AMT_W(AW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .dir(dir), .operand(operand),
        .amount(amount), .busy(busy), .done(done), .err(err), .result(result),
        .su_enable(su_enable), .su_alu_fun(su_alu_fun), .su_a(su_a), .su_b(su_b),
        .su_out(su_out), .su_flag(su_flag)
    );

    // SHIFT_UNIT stand-in: registers a 1-bit shift when enabled, flag marks
    // a valid result in the following cycle.
    assign su_rst_n = ~RST;
    always_ff @(posedge CLK or negedge su_rst_n) begin
        if (!su_rst_n) begin
            m_out  <= '0;
            m_flag <= 1'b0;
        end else if (su_enable) begin
            case (su_alu_fun)
                SH_A_RIGHT: m_out <= su_a >> 1;
                SH_A_LEFT:  m_out <= su_a << 1;
                SH_B_RIGHT: m_out <= su_b >> 1;
                default:    m_out <= su_b << 1;
            endcase
            m_flag <= 1'b1;
        end else begin
            m_flag <= 1'b0;
        end
    end
    assign su_out  = m_out;
    assign su_flag = m_flag & ~kill;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Start cycle is cycle 0; cycle k is observed at the k-th negedge after it.
    task automatic run_op(input string nm, input logic [W-1:0] opd, input logic d,
                          input logic [AW-1:0] amt, input logic [W-1:0] exp_res,
                          input int exp_done, input int exp_en, input logic exp_err,
                          input int inj_cyc, input int kill_cyc, input int rst_cyc);
        int cyc;
        int en_cnt;
        int done_cyc;
        @(negedge CLK);
        start = 1'b1; operand = opd; dir = d; amount = amt;
        cyc = 0; en_cnt = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) start = 1'b0;
            kill = 1'b0;
            if (su_enable) begin
                en_cnt++;
                chk({nm, ".fun"}, 32'(su_alu_fun), {30'd0, 1'b0, d});
            end
            if (done) begin
                done_cyc = cyc;
                chk({nm, ".err"}, 32'(err), 32'(exp_err));
            end
            if (cyc == kill_cyc) kill = 1'b1;
            if (inj_cyc > 0 && cyc == inj_cyc) begin
                start = 1'b1; operand = ~opd; dir = ~d; amount = 5'd7;
            end
            if (inj_cyc > 0 && cyc == inj_cyc + 1) start = 1'b0;
            if (cyc == rst_cyc) begin
                RST = 1'b1;
                @(negedge CLK);
                chk({nm, ".rst_busy"}, 32'(busy), 32'd0);
                chk({nm, ".rst_result"}, 32'(result), 32'd0);
                chk({nm, ".rst_done"}, 32'(done), 32'd0);
                chk({nm, ".rst_en"}, 32'(su_enable), 32'd0);
                RST = 1'b0;
                return;
            end
        end
        chk({nm, ".done_cyc"}, 32'(done_cyc), 32'(exp_done));
        chk({nm, ".en_cnt"}, 32'(en_cnt), 32'(exp_en));
        @(negedge CLK);
        chk({nm, ".result"}, 32'(result), 32'(exp_res));
        chk({nm, ".done_low"}, 32'(done), 32'd0);
        chk({nm, ".busy_low"}, 32'(busy), 32'd0);
        chk({nm, ".err_low"}, 32'(err), 32'd0);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; dir = 1'b0; operand = '0; amount = '0; kill = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.result", 32'(result), 32'd0);
        chk("reset.su_en", 32'(su_enable), 32'd0);
        chk("reset.su_fun", 32'(su_alu_fun), 32'd0);
        chk("reset.su_a", 32'(su_a), 32'd0);
        RST = 1'b0;

        //     name        operand   dir  amt    result    done en err inj kill rst
        run_op("lsl1",     16'h8001, 1'b1, 5'd1,  16'h0002, 3,  1, 1'b0, 0, 0, 0);
        run_op("lsr4",     16'hF0F0, 1'b0, 5'd4,  16'h0F0F, 9,  4, 1'b0, 0, 0, 0);
        run_op("amt0",     16'h1234, 1'b0, 5'd0,  16'h1234, 1,  0, 1'b0, 0, 0, 0);
        run_op("sat20",    16'hFFFF, 1'b1, 5'd20, 16'h0000, 33, 16, 1'b0, 0, 0, 0);
        run_op("busy_ign", 16'h0001, 1'b1, 5'd3,  16'h0008, 7,  3, 1'b0, 2, 0, 0);
        run_op("mid_rst",  16'h00FF, 1'b1, 5'd5,  16'h0000, 0,  0, 1'b0, 0, 0, 4);
        run_op("post_rst", 16'h0003, 1'b1, 5'd2,  16'h000C, 5,  2, 1'b0, 0, 0, 0);
        run_op("flag_err", 16'h0001, 1'b1, 5'd3,  16'h0002, 3,  1, 1'b1, 0, 2, 0);
        run_op("after_err",16'hA5A5, 1'b0, 5'd1,  16'h52D2, 3,  1, 1'b0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
